// File: rtl/uncover_flood_fill_if.sv
// Request/memory bundle for the uncover reveal engine.
//   start/startX/startY/gridWidth/gridHeight : uncover request from the game FSM
//   memAddr/memRdData/memWrEn/memWrData     : single grid memory port (combinational read)
//   busy/done/hitBomb/revealedCount          : status back to the game FSM
// master = game FSM + grid memory side, slave = reveal engine.
interface uncover_flood_fill_if;
    logic       start;
    logic [3:0] startX;
    logic [3:0] startY;
    logic [3:0] gridWidth;
    logic [3:0] gridHeight;
    logic [7:0] memAddr;
    logic [6:0] memRdData;
    logic       memWrEn;
    logic [6:0] memWrData;
    logic       busy;
    logic       done;
    logic       hitBomb;
    logic [7:0] revealedCount;

    modport master (
        output start, startX, startY, gridWidth, gridHeight, memRdData,
        input  memAddr, memWrEn, memWrData, busy, done, hitBomb, revealedCount
    );

    modport slave (
        input  start, startX, startY, gridWidth, gridHeight, memRdData,
        output memAddr, memWrEn, memWrData, busy, done, hitBomb, revealedCount
    );
endinterface

// File: rtl/uncover_flood_fill.sv
// Minesweeper reveal engine. Takes one uncover request and performs the full
// reveal through a single grid memory port: a numbered cell is uncovered alone,
// a bomb is overwritten with the exploded marker, and a blank cell starts a
// breadth-first flood over connected blanks plus their numbered border.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : slave side of uncover_flood_fill_if (request, memory port, status)
// Element format: [0] uncovered, [1] bomb, [2] flag, [6:3] bombsNear.
module uncover_flood_fill #(
    parameter int QUEUE_DEPTH = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    uncover_flood_fill_if.slave  bus
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_DEPTH - 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(QUEUE_DEPTH);
    localparam logic [6:0]    BOMB_EXPLODE = 7'h7F;

    typedef enum logic [2:0] {IDLE, SEED, POP, SCAN, DONE} state_t;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } cell_t;

    state_t      state, state_nxt;
    cell_t       lat_cell;     // latched start cell
    logic [3:0]  lat_w, lat_h; // latched max column/row index
    cell_t       cur;          // cell currently being scanned
    logic [2:0]  dir;
    logic [7:0]  count;
    logic        hit_bomb;

    cell_t       q_mem [QUEUE_DEPTH];
    logic [PW-1:0] head, tail;
    logic [OW-1:0] occ;

    logic        push, pop;
    cell_t       push_val;
    logic [7:0]  addr;
    logic        wr_en;
    logic [6:0]  wr_data;

    // neighbour decode
    logic        up, down, left, right, nb_ok;
    cell_t       nb;

    // read-data fields
    logic        rd_uncov, rd_bomb, rd_flag;
    logic [3:0]  rd_near;

    assign rd_uncov = bus.memRdData[0];
    assign rd_bomb  = bus.memRdData[1];
    assign rd_flag  = bus.memRdData[2];
    assign rd_near  = bus.memRdData[6:3];

    function automatic logic [7:0] cell_addr(input cell_t c, input logic [3:0] w);
        return 8'(c.x) + 8'(c.y) * (8'(w) + 8'd1);
    endfunction

    // dir 0..7 = N, S, W, E, NW, NE, SW, SE. Range tests are taken on the
    // unmodified coordinate so an edge cell never wraps to the far side.
    always_comb begin
        up    = (dir == 3'd0) || (dir == 3'd4) || (dir == 3'd5);
        down  = (dir == 3'd1) || (dir == 3'd6) || (dir == 3'd7);
        left  = (dir == 3'd2) || (dir == 3'd4) || (dir == 3'd6);
        right = (dir == 3'd3) || (dir == 3'd5) || (dir == 3'd7);
        nb_ok = !((up    && cur.y == 4'd0)  ||
                  (down  && cur.y >= lat_h) ||
                  (left  && cur.x == 4'd0)  ||
                  (right && cur.x >= lat_w));
        nb.x  = left ? cur.x - 4'd1 : (right ? cur.x + 4'd1 : cur.x);
        nb.y  = up   ? cur.y - 4'd1 : (down  ? cur.y + 4'd1 : cur.y);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        addr      = 8'd0;
        wr_en     = 1'b0;
        wr_data   = 7'd0;
        push      = 1'b0;
        push_val  = lat_cell;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = SEED;
            end
            SEED: begin
                if (lat_cell.x > lat_w || lat_cell.y > lat_h) begin
                    // keep the port on a legal address when the request is bogus
                    state_nxt = DONE;
                end else begin
                    addr = cell_addr(lat_cell, lat_w);
                    if (rd_uncov || rd_flag) begin
                        state_nxt = DONE;
                    end else if (rd_bomb) begin
                        wr_en     = 1'b1;
                        wr_data   = BOMB_EXPLODE;
                        state_nxt = DONE;
                    end else begin
                        wr_en   = 1'b1;
                        wr_data = bus.memRdData | 7'd1;
                        if (rd_near == 4'd0) begin
                            push      = 1'b1;
                            state_nxt = POP;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            POP: begin
                if (occ == '0) begin
                    state_nxt = DONE;
                end else begin
                    pop       = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                // out-of-range neighbours park the port on the centre cell
                addr = nb_ok ? cell_addr(nb, lat_w) : cell_addr(cur, lat_w);
                if (nb_ok && !rd_uncov && !rd_flag && !rd_bomb) begin
                    wr_en   = 1'b1;
                    wr_data = bus.memRdData | 7'd1;
                    if (rd_near == 4'd0) begin
                        push     = 1'b1;
                        push_val = nb;
                    end
                end
                if (dir == 3'd7) state_nxt = POP;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // request latch, scan cursor, result registers, queue pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cell <= '0;
            lat_w    <= '0;
            lat_h    <= '0;
            cur      <= '0;
            dir      <= '0;
            count    <= '0;
            hit_bomb <= 1'b0;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                lat_cell <= '{y: bus.startY, x: bus.startX};
                lat_w    <= bus.gridWidth;
                lat_h    <= bus.gridHeight;
                count    <= '0;
                hit_bomb <= 1'b0;
            end
            if (state == SEED && wr_en) begin
                if (rd_bomb) hit_bomb <= 1'b1;
                else         count    <= 8'd1;
            end
            if (state == SCAN) begin
                dir <= dir + 3'd1;
                if (wr_en) count <= count + 8'd1;
            end
            // push and pop are never requested in the same cycle
            if (pop) begin
                cur  <= q_mem[head];
                dir  <= '0;
                head <= (head == PTR_LAST) ? '0 : head + 1'b1;
                occ  <= occ - 1'b1;
            end else if (push && occ != OCC_FULL) begin
                tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
                occ  <= occ + 1'b1;
            end
        end
    end

    // queue storage needs no reset; emptiness lives in occ
    always_ff @(posedge clock) begin
        if (!reset && push && occ != OCC_FULL) q_mem[tail] <= push_val;
    end

    assign bus.memAddr       = addr;
    assign bus.memWrEn       = wr_en & ~reset;
    assign bus.memWrData     = wr_data;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.hitBomb       = hit_bomb;
    assign bus.revealedCount = count;
endmodule
